// File: rtl/nmr_acq_echo_capture.sv
// nmr_acq_echo_capture
//   Multi-echo ADC capture engine. Sits downstream of the RX/duplexer window
//   generator: on each fresh rising edge of the delayed window it writes
//   samples_per_echo ADC words into the acquisition RAM, and it repeats this
//   for num_echoes echoes per arm. acq_en is handed back to the window
//   generator, which holds its window open until acq_en has gone high and then
//   low again.
//
// Ports
//   adc_clk           ADC sample clock (single domain)
//   reset_n           asynchronous active-low reset
//   arm               1-cycle pulse, starts a new multi-echo acquisition
//   acq_wnd_dly       delayed acquisition window from the window generator
//   adc_data          raw ADC sample, valid every cycle
//   samples_per_echo  samples captured per echo (static while busy)
//   num_echoes        echoes per acquisition (static while busy)
//   acq_en            capture in progress for the current echo
//   wr_en/wr_addr/wr_data  acquisition RAM write port
//   echo_cnt          echoes completed since arm
//   busy              high from arm until done
//   done              level, all echoes captured
//   addr_ovf          sticky, RAM address wrapped since arm
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for arm
// ARMED | waiting for a fresh rising edge of acq_wnd_dly
// CAPT  | writing samples for the current echo, acq_en high
// REARM | echo finished, waiting for the window to close
// DONE  | all echoes captured, done held until the next arm

module nmr_acq_echo_capture #(
    parameter int DATABUS_WIDTH = 32,
    parameter int ADC_WIDTH     = 14,
    parameter int ADDR_WIDTH    = 12
) (
    input  logic                     adc_clk,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic                     acq_wnd_dly,
    input  logic [ADC_WIDTH-1:0]     adc_data,
    input  logic [DATABUS_WIDTH-1:0] samples_per_echo,
    input  logic [DATABUS_WIDTH-1:0] num_echoes,
    output logic                     acq_en,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [ADC_WIDTH-1:0]     wr_data,
    output logic [DATABUS_WIDTH-1:0] echo_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     addr_ovf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_CAPT  = 3'd2,
        S_REARM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic                     wnd_q;
    logic                     rise;
    logic [DATABUS_WIDTH-1:0] scnt_q, scnt_d;
    logic [DATABUS_WIDTH-1:0] echo_cnt_d, echo_inc;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_d;
    logic [ADC_WIDTH-1:0]     wr_data_d;
    logic                     wrapped_q, wrapped_d;
    logic                     acq_en_d, wr_en_d, busy_d, done_d, addr_ovf_d;

    assign rise     = acq_wnd_dly & ~wnd_q;
    assign echo_inc = echo_cnt + DATABUS_WIDTH'(1);

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wnd_q     <= 1'b0;
            scnt_q    <= '0;
            addr_q    <= '0;
            wrapped_q <= 1'b0;
            acq_en    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            echo_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_ovf  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wnd_q     <= acq_wnd_dly;
            scnt_q    <= scnt_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
            acq_en    <= acq_en_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            echo_cnt  <= echo_cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            addr_ovf  <= addr_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        addr_d     = addr_q;
        wrapped_d  = wrapped_q;
        acq_en_d   = acq_en;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        echo_cnt_d = echo_cnt;
        busy_d     = busy;
        done_d     = done;
        addr_ovf_d = addr_ovf;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A rise coincident with arm only arms; wnd_q absorbs it so
                // ARMED needs a fresh edge.
                if (arm) begin
                    echo_cnt_d = '0;
                    addr_d     = '0;
                    wrapped_d  = 1'b0;
                    addr_ovf_d = 1'b0;
                    acq_en_d   = 1'b0;
                    if (num_echoes == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        state_d = S_ARMED;
                    end
                end
            end

            S_ARMED: begin
                if (rise) begin
                    acq_en_d = 1'b1;
                    scnt_d   = '0;
                    state_d  = S_CAPT;
                end
            end

            S_CAPT: begin
                // The window is deliberately not looked at here: a capture,
                // once started, always completes its samples. acq_en drops
                // the edge after the last write, so with zero samples it is
                // still high for one cycle and the window generator can close.
                if (scnt_q != samples_per_echo) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = adc_data;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    scnt_d    = scnt_q + DATABUS_WIDTH'(1);
                    if (wrapped_q) begin
                        addr_ovf_d = 1'b1;
                    end
                    if (&addr_q) begin
                        wrapped_d = 1'b1;
                    end
                end else begin
                    acq_en_d   = 1'b0;
                    echo_cnt_d = echo_inc;
                    if (echo_inc == num_echoes) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REARM;
                    end
                end
            end

            S_REARM: begin
                if (!acq_wnd_dly) begin
                    state_d = S_ARMED;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
